// File: rtl/noc_input_buffer.sv
// Per-direction NoC router input buffer.
// Checks packet framing on the write side and drops malformed flits.
// It holds accepted flits in a FIFO and presents the head flit to the arbiter and crossbar.
//
// Handshake: a flit transfers on a posedge where in_valid && in_ready.
// in_ready depends only on the stored occupancy and never on grant.
// Every transferred flit is either enqueued or dropped, and a dropped flit still completes its transfer.
// A pop happens on a posedge where grant && req.
module noc_input_buffer #(
   parameter int FLIT_W = 32,
   parameter int DEPTH  = 8,
   parameter int DROP_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [FLIT_W-1:0]          in_flit,
   output logic                       in_ready,
   input  logic                       grant,
   output logic                       req,
   output logic [2:0]                 flit_id,
   output logic [11:0]                length,
   output logic [FLIT_W-1:0]          out_flit,
   output logic [$clog2(DEPTH):0]     count,
   output logic [DROP_W-1:0]          drop_cnt,
   output logic                       wr_state_dbg
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   localparam logic [2:0] ID_HDR  = 3'b001;
   localparam logic [2:0] ID_BODY = 3'b010;
   localparam logic [2:0] ID_TAIL = 3'b100;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_PKT  = 1'b1
   } wr_state_e;

   wr_state_e          state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic [FLIT_W-1:0]  mem_q [DEPTH];
   logic [FLIT_W-1:0]  mem_d [DEPTH];

   logic        accept;
   logic        push;
   logic        drop;
   logic        pop;
   logic        empty;
   logic [2:0]  in_id;
   logic [FLIT_W-1:0] head;

   assign in_id    = in_flit[FLIT_W-1 -: 3];
   assign empty    = (count_q == '0);
   assign in_ready = (count_q < FULL_CNT);
   assign accept   = in_valid && in_ready;
   assign pop      = grant && !empty;

   // Framing FSM: decide whether an accepted flit is enqueued or dropped
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      drop    = 1'b0;
      unique case (state_q)
         W_IDLE: begin
            if (accept) begin
               if (in_id == ID_HDR) begin
                  push    = 1'b1;
                  state_d = W_PKT;
               end else begin
                  drop = 1'b1;
               end
            end
         end
         W_PKT: begin
            if (accept) begin
               if (in_id == ID_BODY) begin
                  push = 1'b1;
               end else if (in_id == ID_TAIL) begin
                  push    = 1'b1;
                  state_d = W_IDLE;
               end else begin
                  drop = 1'b1;
               end
            end
         end
         default: state_d = W_IDLE;
      endcase
   end

   // FIFO pointers, occupancy, storage and saturating drop counter next-state
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      drop_cnt_d = drop_cnt_q;
      mem_d      = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = in_flit;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (drop && (drop_cnt_q != {DROP_W{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
   end

   // Control registers; reset empties the FIFO and abandons any partial packet
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= W_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Flit storage; contents are only visible through a valid head, so no reset needed
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Head presentation is combinational from the read pointer and is forced to zero when empty
   assign head         = mem_q[rd_ptr_q];
   assign req          = !empty;
   assign out_flit     = empty ? '0 : head;
   assign flit_id      = out_flit[FLIT_W-1 -: 3];
   assign length       = out_flit[11:0];
   assign count        = count_q;
   assign drop_cnt     = drop_cnt_q;
   assign wr_state_dbg = state_q;

endmodule

// File: tb/tb_noc_input_buffer.sv
// Self-checking bench for noc_input_buffer.
// A behavioural framing model predicts enqueue/drop and occupancy.
// Enqueued flits go to exp_q, and a negedge monitor compares each popped head flit against it.
module tb_noc_input_buffer;

  localparam int FLIT_W = 32;
  localparam int DEPTH  = 8;
  localparam int DROP_W = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [FLIT_W-1:0] in_flit;
  logic              in_ready;
  logic              grant;
  logic              req;
  logic [2:0]        flit_id;
  logic [11:0]       length;
  logic [FLIT_W-1:0] out_flit;
  logic [$clog2(DEPTH):0] count;
  logic [DROP_W-1:0] drop_cnt;
  logic              wr_state_dbg;

  noc_input_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_flit      (in_flit),
    .in_ready     (in_ready),
    .grant        (grant),
    .req          (req),
    .flit_id      (flit_id),
    .length       (length),
    .out_flit     (out_flit),
    .count        (count),
    .drop_cnt     (drop_cnt),
    .wr_state_dbg (wr_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // model state
  logic [FLIT_W-1:0] exp_q[$];
  int m_count = 0;
  int m_drop  = 0;
  bit m_pkt   = 1'b0;

  // scoreboard monitor: compare the head flit whenever a pop is about to happen
  always @(negedge clk) begin
    if (!rst && grant && req) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop_unexpected: got out_flit %h, expected no flit", out_flit);
        fails++;
      end else begin
        if (out_flit !== exp_q[0]) begin
          $display("FAIL pop_data: got %h, expected %h", out_flit, exp_q[0]);
          fails++;
        end
        void'(exp_q.pop_front());
      end
    end
  end

  function automatic logic [FLIT_W-1:0] mk(input logic [2:0] id, input logic [11:0] len);
    logic [FLIT_W-16:0] mid;
    mid = FLIT_W'($urandom) >> 12;
    return {id, mid[FLIT_W-16:0], len};
  endfunction

  // driver: apply one cycle of stimulus, update the model, advance to #1 after the edge
  task automatic step(input logic v, input logic [FLIT_W-1:0] f, input logic g);
    logic [2:0] id;
    bit acc, enq, pop_m;
    in_valid = v;
    in_flit  = f;
    grant    = g;
    id    = f[FLIT_W-1 -: 3];
    pop_m = g && (m_count > 0);
    acc   = v && (m_count < DEPTH);
    enq   = 1'b0;
    if (acc) begin
      if (!m_pkt) begin
        if (id == 3'b001) begin enq = 1'b1; m_pkt = 1'b1; end
        else if (m_drop < DROP_MAX) m_drop++;
      end else begin
        if (id == 3'b010) enq = 1'b1;
        else if (id == 3'b100) begin enq = 1'b1; m_pkt = 1'b0; end
        else if (m_drop < DROP_MAX) m_drop++;
      end
    end
    if (enq) exp_q.push_back(f);
    m_count = m_count + int'(enq) - int'(pop_m);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    grant    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    grant = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_count = 0;
    m_drop  = 0;
    m_pkt   = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && m_count > 0; i++) step(1'b0, '0, 1'b1);
    checks++;
    if (count !== 0 || exp_q.size() != 0) begin
      $display("FAIL drain: count %0d, %0d flits still expected", count, exp_q.size());
      fails++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (req !== 1'b0 || flit_id !== 3'b000 || length !== 12'd0 || out_flit !== '0 ||
        in_ready !== 1'b1 || count !== 0 || drop_cnt !== 0 || wr_state_dbg !== 1'b0) begin
      $display("FAIL reset_state: req %b id %b len %0d flit %h rdy %b cnt %0d drop %0d st %b, expected all idle with in_ready 1",
               req, flit_id, length, out_flit, in_ready, count, drop_cnt, wr_state_dbg);
      fails++;
    end
  endtask

  task automatic test_basic();
    logic [2:0] ids [3];
    ids[0] = 3'b001; ids[1] = 3'b010; ids[2] = 3'b100;
    do_reset();
    step(1'b1, mk(3'b001, 12'd20), 1'b0);
    checks++;
    if (req !== 1'b1 || flit_id !== 3'b001) begin
      $display("FAIL basic_latency: req %b id %b, expected 1 001", req, flit_id);
      fails++;
    end
    step(1'b1, mk(3'b010, 12'h5a5), 1'b0);
    step(1'b1, mk(3'b100, 12'h0f0), 1'b0);
    checks++;
    if (count !== 3 || req !== 1'b1 || flit_id !== 3'b001 || length !== 12'd20) begin
      $display("FAIL basic_loaded: cnt %0d req %b id %b len %0d, expected 3 1 001 20", count, req, flit_id, length);
      fails++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (flit_id !== ids[i]) begin
        $display("FAIL basic_id_seq%0d: got %b, expected %b", i, flit_id, ids[i]);
        fails++;
      end
      step(1'b0, '0, 1'b1);
    end
    checks++;
    if (req !== 1'b0 || count !== 0 || out_flit !== '0) begin
      $display("FAIL basic_empty: req %b cnt %0d flit %h, expected 0 0 0", req, count, out_flit);
      fails++;
    end
  endtask

  task automatic test_full();
    do_reset();
    step(1'b1, mk(3'b001, 12'd8), 1'b0);
    for (int i = 0; i < DEPTH - 2; i++) step(1'b1, mk(3'b010, 12'(i)), 1'b0);
    step(1'b1, mk(3'b100, 12'd0), 1'b0);
    checks++;
    if (count !== DEPTH || in_ready !== 1'b0) begin
      $display("FAIL full_level: cnt %0d rdy %b, expected %0d 0", count, in_ready, DEPTH);
      fails++;
    end
    step(1'b1, mk(3'b001, 12'd1), 1'b0);
    checks++;
    if (count !== DEPTH || drop_cnt !== 0) begin
      $display("FAIL full_reject: cnt %0d drop %0d, expected %0d 0", count, drop_cnt, DEPTH);
      fails++;
    end
    step(1'b0, '0, 1'b1);
    checks++;
    if (count !== DEPTH - 1 || in_ready !== 1'b1) begin
      $display("FAIL full_pop: cnt %0d rdy %b, expected %0d 1", count, in_ready, DEPTH - 1);
      fails++;
    end
    // refill to full, then offer a flit while grant is high: no bypass
    step(1'b1, mk(3'b001, 12'd2), 1'b0);
    step(1'b1, mk(3'b010, 12'd3), 1'b1);
    checks++;
    if (count !== DEPTH - 1 || drop_cnt !== 0) begin
      $display("FAIL full_grant_no_bypass: cnt %0d drop %0d, expected %0d 0", count, drop_cnt, DEPTH - 1);
      fails++;
    end
    step(1'b1, mk(3'b100, 12'd4), 1'b0);
    drain();
  endtask

  task automatic test_drop_idle();
    do_reset();
    step(1'b1, mk(3'b010, 12'd1), 1'b0);
    step(1'b1, mk(3'b100, 12'd2), 1'b0);
    step(1'b1, mk(3'b111, 12'd3), 1'b0);
    checks++;
    if (drop_cnt !== 3 || count !== 0 || req !== 1'b0) begin
      $display("FAIL drop_idle: drop %0d cnt %0d req %b, expected 3 0 0", drop_cnt, count, req);
      fails++;
    end
  endtask

  task automatic test_dup_header();
    do_reset();
    step(1'b1, mk(3'b001, 12'd7), 1'b0);
    step(1'b1, mk(3'b001, 12'd9), 1'b0);
    step(1'b1, mk(3'b100, 12'd0), 1'b0);
    checks++;
    if (drop_cnt !== 1 || count !== 2 || length !== 12'd7) begin
      $display("FAIL dup_header: drop %0d cnt %0d len %0d, expected 1 2 7", drop_cnt, count, length);
      fails++;
    end
    step(1'b0, '0, 1'b1);
    checks++;
    if (flit_id !== 3'b100) begin
      $display("FAIL dup_header_tail: id %b, expected 100", flit_id);
      fails++;
    end
    drain();
  endtask

  task automatic test_push_pop();
    do_reset();
    step(1'b1, mk(3'b001, 12'd4), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, mk(3'b010, 12'(i)), 1'b0);
    step(1'b1, mk(3'b010, 12'hbee), 1'b1);
    checks++;
    if (count !== 4 || flit_id !== 3'b010 || length !== 12'd0) begin
      $display("FAIL push_pop: cnt %0d id %b len %0d, expected 4 010 0", count, flit_id, length);
      fails++;
    end
    step(1'b1, mk(3'b100, 12'd0), 1'b0);
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, mk(3'b001, 12'd3), 1'b0);
    step(1'b1, mk(3'b010, 12'd1), 1'b0);
    step(1'b1, mk(3'b010, 12'd2), 1'b0);
    do_reset();
    checks++;
    if (count !== 0 || req !== 1'b0 || drop_cnt !== 0 || wr_state_dbg !== 1'b0) begin
      $display("FAIL reset_mid: cnt %0d req %b drop %0d st %b, expected 0 0 0 0", count, req, drop_cnt, wr_state_dbg);
      fails++;
    end
    step(1'b1, mk(3'b010, 12'd5), 1'b0);
    checks++;
    if (drop_cnt !== 1 || count !== 0) begin
      $display("FAIL reset_mid_body: drop %0d cnt %0d, expected 1 0", drop_cnt, count);
      fails++;
    end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    for (int i = 0; i < DROP_MAX + 5; i++) step(1'b1, mk(3'b000, 12'(i)), 1'b0);
    checks++;
    if (drop_cnt !== DROP_W'(DROP_MAX) || count !== 0) begin
      $display("FAIL drop_saturate: drop %0d cnt %0d, expected %0d 0", drop_cnt, count, DROP_MAX);
      fails++;
    end
  endtask

  task automatic test_random();
    logic [2:0] ids [6];
    ids[0] = 3'b001; ids[1] = 3'b010; ids[2] = 3'b010;
    ids[3] = 3'b100; ids[4] = 3'b010; ids[5] = 3'b110;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), mk(ids[$urandom_range(0, 5)], 12'($urandom)),
           1'($urandom_range(0, 2) == 0));
      checks++;
      if (count !== m_count || drop_cnt !== m_drop || in_ready !== (m_count < DEPTH)) begin
        $display("FAIL random_cycle%0d: cnt %0d drop %0d rdy %b, expected %0d %0d %b",
                 i, count, drop_cnt, in_ready, m_count, m_drop, (m_count < DEPTH));
        fails++;
      end
    end
    drain();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_flit = '0;
    grant = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_full();
    test_drop_idle();
    test_dup_header();
    test_push_pop();
    test_reset_mid();
    test_drop_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // global time bound
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time bound, expected completion");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "timeout");
  end

endmodule
